// File: rtl/mem_pkg.sv
// Shared types, widths and the byte-lane merge helper for the memory responder.
package mem_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MEM_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DUMP = 2'd3
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  // Word-address width for a power-of-two depth.
  function automatic int unsigned word_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response and dump signals between the CPU initiators and the memory responder.
interface mem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              createdump;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready, createdump,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  dump_valid, dump_addr, dump_data, dump_done
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready, createdump,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output dump_valid, dump_addr, dump_data, dump_done
  );

endinterface

// File: rtl/mem_responder_array.sv
// Word storage: byte-enabled synchronous write, combinational access read,
// plus a second read port for the dump engine when MEM_RESP_DUMP_EN is defined.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_DEPTH,
  parameter int unsigned AW    = word_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] rdata_o
`ifdef MEM_RESP_DUMP_EN
  ,
  input  logic [AW-1:0]     dump_addr_i,
  output logic [DATA_W-1:0] dump_data_o
`endif
);

  // Contents deliberately survive reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= be_merge(mem_q[addr_i], wdata_i, be_i);
  end

  assign rdata_o = mem_q[addr_i];

`ifdef MEM_RESP_DUMP_EN
  assign dump_data_o = mem_q[dump_addr_i];
`endif

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable wait cycles.
// Optional full-array dump engine enabled by defining MEM_RESP_DUMP_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = MEM_DEPTH,
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_responder_if.slave bus
);

  localparam int unsigned     AW       = word_aw(DEPTH);
  localparam logic [CNT_W-1:0] LAT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_t               req_q, req_d, req_in, req_cur;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               commit_c, hs_req_c, hs_rsp_c, req_ready_c, dump_req_c, err_c, we_c;
  logic [AW-1:0]      widx_c;
  logic [DATA_W-1:0]  rd_word;

  assign req_in = '{wr: bus.req_wr, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};
  // A zero-latency commit happens on the acceptance edge, before req_q holds the request.
  assign req_cur = (state_q == IDLE) ? req_in : req_q;

  assign err_c  = (req_cur.addr[1:0] != 2'b00) ||
                  (req_cur.addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
  assign widx_c = req_cur.addr[AW+1:2];
  assign we_c   = commit_c && req_cur.wr && !err_c;

  assign req_ready_c = rst && (state_q == IDLE) && !dump_req_c;
  assign hs_req_c    = bus.req_valid && req_ready_c;
  assign hs_rsp_c    = rsp_valid_q && bus.rsp_ready;

`ifdef MEM_RESP_DUMP_EN
  logic              pend_q, pend_d;
  logic [AW-1:0]     didx_q, didx_d;
  logic              dvalid_q, ddone_q;
  logic [ADDR_W-1:0] daddr_q;
  logic [DATA_W-1:0] ddata_q, dump_word;

  assign dump_req_c = pend_q || bus.createdump;
`else
  logic unused_createdump;
  assign unused_createdump = bus.createdump;
  assign dump_req_c        = 1'b0;
`endif

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk         (clk),
    .we_i        (we_c),
    .addr_i      (widx_c),
    .wdata_i     (req_cur.wdata),
    .be_i        (req_cur.be),
    .rdata_o     (rd_word)
`ifdef MEM_RESP_DUMP_EN
    ,
    .dump_addr_i (didx_d),
    .dump_data_o (dump_word)
`endif
  );

  // Next-state and response capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit_c    = 1'b0;
`ifdef MEM_RESP_DUMP_EN
    pend_d      = pend_q || (bus.createdump && (state_q != DUMP));
    didx_d      = didx_q;
`endif
    case (state_q)
      IDLE: begin
        if (dump_req_c) begin
`ifdef MEM_RESP_DUMP_EN
          state_d = DUMP;
          pend_d  = 1'b0;
          didx_d  = '0;
`endif
        end else if (hs_req_c) begin
          req_d = req_in;
          if (LATENCY == 0) begin
            state_d  = RESP;
            commit_c = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // First RESP cycle keeps valid low; valid then holds until the handshake.
        if (hs_rsp_c) begin
          state_d = IDLE;
          if (dump_req_c) begin
`ifdef MEM_RESP_DUMP_EN
            state_d = DUMP;
            pend_d  = 1'b0;
            didx_d  = '0;
`endif
          end
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
`ifdef MEM_RESP_DUMP_EN
      DUMP: begin
        if (didx_q == AW'(DEPTH - 1)) state_d = IDLE;
        else                          didx_d  = didx_q + AW'(1);
      end
`endif
      default: state_d = IDLE;
    endcase
    if (commit_c) begin
      rsp_err_d   = err_c;
      rsp_rdata_d = (err_c || req_cur.wr) ? '0 : rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef MEM_RESP_DUMP_EN
  // Dump outputs track the word selected for the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= 1'b0;
      didx_q   <= '0;
      dvalid_q <= 1'b0;
      daddr_q  <= '0;
      ddata_q  <= '0;
      ddone_q  <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      didx_q   <= didx_d;
      dvalid_q <= (state_d == DUMP);
      daddr_q  <= (state_d == DUMP) ? ADDR_W'({didx_d, 2'b00}) : '0;
      ddata_q  <= (state_d == DUMP) ? dump_word : '0;
      ddone_q  <= (state_d == DUMP) && (didx_d == AW'(DEPTH - 1));
    end
  end

  assign bus.dump_valid = dvalid_q;
  assign bus.dump_addr  = daddr_q;
  assign bus.dump_data  = ddata_q;
  assign bus.dump_done  = ddone_q;
`else
  assign bus.dump_valid = 1'b0;
  assign bus.dump_addr  = '0;
  assign bus.dump_data  = '0;
  assign bus.dump_done  = 1'b0;
`endif

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, reset and dump
// sequences, then random traffic against a word-array reference model.
`timescale 1ns/1ps
module tb_mem_responder;

`ifdef MEM_RESP_DUMP_EN
  localparam int unsigned DEPTH = 16;
`else
  localparam int unsigned DEPTH = 1024;
`endif
  localparam int unsigned LAT    = 2;
  localparam int unsigned N_RAND = 300;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  mem_responder_if bus ();

  mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_err(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr / 4 >= DEPTH);
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) model_mem[addr / 4][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " req_ready"},  bus.req_ready,  32'd0);
    check({tag, " rsp_valid"},  bus.rsp_valid,  32'd0);
    check({tag, " rsp_rdata"},  bus.rsp_rdata,  32'd0);
    check({tag, " rsp_err"},    bus.rsp_err,    32'd0);
    check({tag, " dump_valid"}, bus.dump_valid, 32'd0);
    check({tag, " dump_addr"},  bus.dump_addr,  32'd0);
    check({tag, " dump_data"},  bus.dump_data,  32'd0);
    check({tag, " dump_done"},  bus.dump_done,  32'd0);
  endtask

  // One complete request/response; hold = cycles rsp_ready stays low after valid.
  task automatic do_txn(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n;
    bit ok;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({name, " accept_wait"}, 32'(n), 32'd0);
    if (n >= 20) begin
      bus.req_valid = 1'b0;
      return;
    end
    tick();
    bus.req_valid = 1'b0;
    n  = 0;
    ok = 1'b1;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      if (bus.req_ready !== 1'b0) ok = 1'b0;
      tick();
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(LAT + 1));
    check({name, " busy_ready"}, 32'(ok), 32'd1);
    if (bus.rsp_valid !== 1'b1) return;
    check({name, " rdata"}, bus.rsp_rdata, exp_rd);
    check({name, " err"}, bus.rsp_err, 32'(exp_err));
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (!(bus.rsp_valid === 1'b1 && bus.rsp_rdata === exp_rd &&
            bus.rsp_err === exp_err && bus.req_ready === 1'b0)) ok = 1'b0;
      tick();
    end
    if (hold > 0) check({name, " hold"}, 32'(ok), 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({name, " post"}, 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
  endtask

  initial begin
    vec_t        vecs [15];
    logic [31:0] oor, last, d, addr, wd, exp_rd;
    logic [3:0]  be;
    logic        wr, e;
    int          kind, idx, n;

    bus.req_valid  = 1'b0;
    bus.req_wr     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_be     = '0;
    bus.rsp_ready  = 1'b0;
    bus.createdump = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;
    #1;
    check("reset_release req_ready", bus.req_ready, 32'd1);
    tick();

    // Give every word a known value before any read.
    for (int i = 0; i < int'(DEPTH); i++) begin
      d = $urandom | 32'h1;
      do_txn("fill", 1'b1, 32'(i * 4), d, 4'hF, 0, 32'h0, 1'b0);
      model_mem[i] = d;
    end

    oor  = 32'(4 * DEPTH);
    last = 32'(4 * DEPTH - 4);
    vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF,    0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10, 32'h0,        4'h0,    0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10, 32'h0,        4'h0,    0, 32'hDEADAAEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h13, 32'h0,        4'h0,    0, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, oor,    32'h0,        4'h0,    0, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h12, 32'h11223344, 4'hF,    0, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, oor,    32'h55667788, 4'hF,    0, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h10, 32'h0,        4'h0,    0, 32'hDEADAAEF, 1'b0};
    vecs[9]  = '{1'b1, 32'h10, 32'hFFFFFFFF, 4'h0,    0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h10, 32'h0,        4'h0,    5, 32'hDEADAAEF, 1'b0};
    vecs[11] = '{1'b1, last,   32'hCAFEF00D, 4'hF,    0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, last,   32'h0,        4'h0,    2, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b1, 32'h11, 32'h0,        4'hF,    1, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 32'h0,  32'h0,        4'h0,    0, model_mem[0], 1'b0};

    for (int i = 0; i < 15; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_err);
      if (vecs[i].wr && !vecs[i].exp_err) ref_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
    end

    // Reset during the wait phase of a write: the write must never land.
    do_txn("pre_rst_rd", 1'b0, 32'h20, 32'h0, 4'h0, 0, model_mem[8], 1'b0);
    bus.req_wr    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = ~model_mem[8];
    bus.req_be    = 4'hF;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_reset_release req_ready", bus.req_ready, 32'd1);
    tick();
    do_txn("post_rst_rd", 1'b0, 32'h20, 32'h0, 4'h0, 0, model_mem[8], 1'b0);

`ifdef MEM_RESP_DUMP_EN
    // createdump while a response is pending: dump follows the handshake.
    bus.req_wr    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("dump_rsp_arrive", bus.rsp_valid, 32'd1);
    bus.createdump = 1'b1;
    tick();
    bus.createdump = 1'b0;
    tick();
    check("dump_pending req_ready", bus.req_ready, 32'd0);
    check("dump_pending rdata", bus.rsp_rdata, model_mem[0]);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      check($sformatf("dump%0d addr", i), bus.dump_addr, 32'(4 * i));
      check($sformatf("dump%0d data", i), bus.dump_data, model_mem[i]);
      check($sformatf("dump%0d ctrl", i), 32'({bus.dump_valid, bus.dump_done, bus.req_ready}),
            32'({1'b1, (i == int'(DEPTH) - 1), 1'b0}));
      tick();
    end
    check("dump_end", 32'({bus.dump_valid, bus.req_ready}), 32'b01);

    // createdump and req_valid together in IDLE: the dump wins.
    bus.createdump = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_wr     = 1'b1;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = ~model_mem[0];
    bus.req_be     = 4'hF;
    #1;
    check("dump_wins req_ready", bus.req_ready, 32'd0);
    tick();
    bus.createdump = 1'b0;
    bus.req_valid  = 1'b0;
    n = 0;
    while (bus.dump_done !== 1'b1 && n < int'(DEPTH) + 4) begin
      tick();
      n++;
    end
    check("dump_wins done", bus.dump_done, 32'd1);
    tick();
    check("dump_wins idle", 32'({bus.rsp_valid, bus.dump_valid, bus.req_ready}), 32'b001);
    do_txn("dump_wins_rd", 1'b0, 32'h0, 32'h0, 4'h0, 0, model_mem[0], 1'b0);
`else
    // Without the dump engine createdump has no effect.
    bus.createdump = 1'b1;
    #1;
    check("cd_ignored req_ready", bus.req_ready, 32'd1);
    tick();
    check("cd_ignored dump_valid", bus.dump_valid, 32'd0);
    bus.createdump = 1'b0;
`endif

    for (int k = 0; k < int'(N_RAND); k++) begin
      kind = int'($urandom_range(0, 9));
      idx  = int'($urandom_range(0, DEPTH - 1));
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      be   = 4'($urandom);
      if (kind == 0)      addr = 32'(idx * 4) + 32'($urandom_range(1, 3));
      else if (kind == 1) addr = ($urandom | 32'(4 * DEPTH)) & 32'hFFFF_FFFC;
      else                addr = 32'(idx * 4);
      e = ref_err(addr);
      exp_rd = 32'h0;
      if (!wr && !e) exp_rd = model_mem[addr / 4];
      do_txn("rand", wr, addr, wd, be, int'($urandom_range(0, 3)), exp_rd, e);
      if (wr && !e) ref_write(addr, wd, be);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data/instruction memory responder on the CPU's valid/ready memory request interface: the fetch and load/store paths act as initiators, this block is the responding end. It accepts one read or write request at a time, inserts a programmable number of wait cycles, and returns a response with data and an error flag under backpressure. An optional dump engine streams the whole array out on request for simulation checking.

## Interface
- DEPTH, 1024, number of 32-bit words stored (power of two)
- LATENCY, 2, wait cycles between request acceptance and response (0..15)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  initiator has a request
- req_ready  output  1  responder can accept a request this cycle
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_wdata  input  32  write data
- req_be  input  4  byte enables for writes (bit i = byte lane i)
- rsp_valid  output  1  response available
- rsp_ready  input  1  initiator accepts response
- rsp_rdata  output  32  read data (0 for writes and errors)
- rsp_err  output  1  misaligned or out-of-range access
- createdump  input  1  request a full-array dump
- dump_valid  output  1  dump word valid
- dump_addr  output  32  byte address of dump word
- dump_data  output  32  dump word
- dump_done  output  1  one-cycle pulse with last dump word

## Operation
- States: IDLE, WAIT, RESP, DUMP.
- IDLE: req_ready = 1 unless a dump is pending or createdump is high. Handshake (req_valid & req_ready) latches wr/addr/wdata/be; go to WAIT (LATENCY>0) or RESP (LATENCY=0).
- WAIT: down-counter loaded with LATENCY-1; at 0 go to RESP.
- Commit on the WAIT->RESP (or IDLE->RESP) transition: write merges enabled bytes into mem[addr[31:2]]; read captures mem word into rsp_rdata.
- Error: addr[1:0] != 0 or addr[31:2] >= DEPTH -> rsp_err = 1, write suppressed, rsp_rdata = 0, same latency.
- RESP: rsp_valid held with stable rdata/err until rsp_ready; then to IDLE (or DUMP if pending).
- req_be = 0 on write: legal, no bytes change, normal ack.
- Memory contents are not cleared by reset.

## Timing
- Request accepted at edge T; rsp_valid rises after edge T+1+LATENCY; one request in flight max.
- Back-to-back: earliest next acceptance is the cycle after rsp handshake (req_ready low in WAIT/RESP/DUMP).
- Reset values: req_ready 0 while rst low, 1 first cycle after release; rsp_valid 0, rsp_rdata 0, rsp_err 0, dump_valid 0, dump_addr 0, dump_data 0, dump_done 0; state IDLE, counter 0, dump pending 0.
- Reset mid-operation: transaction dropped; an uncommitted write is never written.
- createdump high in any non-DUMP state sets pending; dump starts only from IDLE or after the RESP handshake. createdump and req_valid both high in IDLE: dump wins, request not accepted.
- DUMP: DEPTH consecutive cycles, dump_valid = 1, dump_addr = 4*i, dump_data = mem[i], i = 0..DEPTH-1, no backpressure; dump_done with i = DEPTH-1; then IDLE. createdump during DUMP ignored.

## Configuration
- MEM_RESP_DUMP_EN defined: DUMP state, pending flag and dump outputs as above.
- Not defined: createdump ignored, DUMP state absent, dump_* outputs tied 0, req_ready depends only on state.

## Structure
- Package mem_pkg: state enum (IDLE, WAIT, RESP, DUMP), word-address width derived from DEPTH, byte-merge function.
- One sub-module: mem_array (synchronous write with byte enables, read port for access and a second read port for dump).

## Test plan
- LATENCY=2: write 0xDEADBEEF to 0x10 at T, rsp_valid at T+3 with err 0; read 0x10 -> rdata 0xDEADBEEF.
- Write be=4'b0010 data 0x0000AA00 to 0x10 -> subsequent read 0xDEADAABE... precisely 0xDEADAAEF.
- Read 0x13 (misaligned) and 0x1000 with DEPTH=1024 -> rsp_err 1, rdata 0; contents unchanged.
- Hold rsp_ready low 5 cycles -> rsp_valid/rdata stable, req_ready 0 throughout; release -> next request accepted following cycle.
- Assert rst low during WAIT of a write to 0x20 -> outputs at reset values; read 0x20 returns prior value.
- MEM_RESP_DUMP_EN, DEPTH=16: createdump during RESP -> after handshake, 16 dump words, addr 0x00..0x3C, dump_done at 0x3C, req not accepted until done.
